// File: rtl/decode_stage.sv
// decode_stage: registered N-wide decode stage between fetch and rename.
// Each lane is decoded combinationally on input; decoded bundles are held in a
// two-entry FIFO (skid buffer) so in_ready comes straight from a flop.
// An illegal instruction squashes younger lanes and halts intake until flush.
// Optional build macro DECODE_NOP_ELIM_EN: nop lanes are dropped, and bundles
// left with nothing to deliver are accepted but not enqueued.

package decode_pkg;
  localparam logic [2:0] FU_ALU = 3'd0;
  localparam logic [2:0] FU_BR  = 3'd1;
  localparam logic [2:0] FU_LD  = 3'd2;
  localparam logic [2:0] FU_ST  = 3'd3;
  localparam logic [2:0] FU_JMP = 3'd4;
  localparam logic [2:0] FU_SYS = 3'd5;

  typedef struct packed {
    logic [2:0]  fu;
    logic [2:0]  funct3;
    logic        alt;     // sub/sra selector
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_we;
    logic        nop;     // architecturally no effect (ALU op writing x0)
    logic [31:0] imm;
  } uop_t;
endpackage

// Combinational RV32I decoder for one lane.
module decode
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output uop_t        uop_o,
  output logic        illegal_o
);
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // Classify the opcode, pick the immediate format and check funct legality.
  always_comb begin
    uop_o        = '0;
    uop_o.funct3 = f3;
    uop_o.rd     = instr_i[11:7];
    uop_o.rs1    = instr_i[19:15];
    uop_o.rs2    = instr_i[24:20];
    illegal_o    = 1'b0;
    case (opcode)
      7'h37, 7'h17: begin
        uop_o.fu = FU_ALU; uop_o.rd_we = 1'b1; uop_o.imm = imm_u;
      end
      7'h6F: begin
        uop_o.fu = FU_JMP; uop_o.rd_we = 1'b1; uop_o.imm = imm_j;
      end
      7'h67: begin
        uop_o.fu = FU_JMP; uop_o.rd_we = 1'b1; uop_o.imm = imm_i;
        illegal_o = (f3 != 3'd0);
      end
      7'h63: begin
        uop_o.fu = FU_BR; uop_o.imm = imm_b;
        illegal_o = (f3 == 3'd2) || (f3 == 3'd3);
      end
      7'h03: begin
        uop_o.fu = FU_LD; uop_o.rd_we = 1'b1; uop_o.imm = imm_i;
        illegal_o = (f3 == 3'd3) || (f3 >= 3'd6);
      end
      7'h23: begin
        uop_o.fu = FU_ST; uop_o.imm = imm_s;
        illegal_o = (f3 >= 3'd3);
      end
      7'h13: begin
        uop_o.fu = FU_ALU; uop_o.rd_we = 1'b1; uop_o.imm = imm_i;
        uop_o.alt = (f3 == 3'd5) && instr_i[30];
        illegal_o = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                    ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      7'h33: begin
        uop_o.fu = FU_ALU; uop_o.rd_we = 1'b1;
        uop_o.alt = instr_i[30];
        illegal_o = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      7'h0F, 7'h73: begin
        uop_o.fu = FU_SYS;
      end
      default: illegal_o = 1'b1;
    endcase
    uop_o.nop = !illegal_o && (uop_o.fu == FU_ALU) && (uop_o.rd == 5'd0);
  end
endmodule

module decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_WIDTH  = 32,
  parameter int DECODE_WIDTH = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DECODE_WIDTH*INSTR_WIDTH-1:0] in_instr,
  input  logic [DECODE_WIDTH-1:0]             in_lane_mask,
  output logic                                out_valid,
  input  logic                                out_ready,
  output uop_t [DECODE_WIDTH-1:0]             out_uop,
  output logic [DECODE_WIDTH-1:0]             out_lane_valid,
  output logic [DECODE_WIDTH-1:0]             out_invalid,
  output logic                                halted,
  output logic [CNT_WIDTH-1:0]                instr_count
);
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  typedef struct packed {
    uop_t [DECODE_WIDTH-1:0] uop;
    logic [DECODE_WIDTH-1:0] lane_valid;
    logic [DECODE_WIDTH-1:0] invalid;
  } entry_t;

  uop_t [DECODE_WIDTH-1:0] dec_uop;
  logic [DECODE_WIDTH-1:0] dec_ill;
  entry_t                  new_entry;
  logic                    older_bad, keep;

  state_e                  state_q, state_d;
  entry_t                  entry_q [2];
  entry_t                  head;
  logic                    rd_ptr_q, rd_ptr_d, wr_ptr;
  logic                    halted_q, halted_d;
  logic                    in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                    in_fire, out_fire, push, pop;

  generate
    for (genvar gi = 0; gi < DECODE_WIDTH; gi++) begin : g_lane
      decode u_decode (
        .instr_i   (in_instr[gi*INSTR_WIDTH +: 32]),
        .uop_o     (dec_uop[gi]),
        .illegal_o (dec_ill[gi])
      );
    end
  endgenerate

  // Qualify lanes: the first masked illegal lane is kept and flagged, younger lanes are squashed.
  always_comb begin
    new_entry     = '0;
    new_entry.uop = dec_uop;
    older_bad     = 1'b0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (in_lane_mask[i] && !older_bad) begin
        new_entry.invalid[i] = dec_ill[i];
`ifdef DECODE_NOP_ELIM_EN
        new_entry.lane_valid[i] = dec_ill[i] || !dec_uop[i].nop;
`else
        new_entry.lane_valid[i] = 1'b1;
`endif
        older_bad = dec_ill[i];
      end
    end
`ifdef DECODE_NOP_ELIM_EN
    keep = (|new_entry.lane_valid) || (|new_entry.invalid);
`else
    keep = 1'b1;
`endif
  end

  // Buffer occupancy FSM next state, handshakes, counter and head-entry outputs.
  always_comb begin
    head           = entry_q[rd_ptr_q];
    out_valid      = (state_q != S_EMPTY);
    out_uop        = head.uop;
    out_lane_valid = out_valid ? head.lane_valid : '0;
    out_invalid    = out_valid ? head.invalid : '0;
    in_fire        = in_valid && in_ready_q;
    out_fire       = out_valid && out_ready;
    push           = in_fire && keep && !flush;
    pop            = out_fire && !flush;
    wr_ptr         = (state_q == S_ONE) ? ~rd_ptr_q : rd_ptr_q;
    rd_ptr_d       = pop ? ~rd_ptr_q : rd_ptr_q;
    cnt_inc        = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      cnt_inc = cnt_inc + CNT_WIDTH'(head.lane_valid[i]);
    end
    cnt_d   = pop ? (cnt_q + cnt_inc) : cnt_q;
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else if (push && !pop) begin
      case (state_q)
        S_EMPTY: state_d = S_ONE;
        S_ONE:   state_d = S_FULL;
        default: state_d = state_q;
      endcase
    end else if (pop && !push) begin
      case (state_q)
        S_FULL:  state_d = S_ONE;
        S_ONE:   state_d = S_EMPTY;
        default: state_d = state_q;
      endcase
    end
    halted_d   = flush ? 1'b0 : (halted_q || (push && (|new_entry.invalid)));
    in_ready_d = (state_d != S_FULL) && !halted_d;
  end

  // State register, pointers, flags, counter and the two buffer entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      rd_ptr_q   <= 1'b0;
      halted_q   <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      halted_q   <= halted_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
      if (push) entry_q[wr_ptr] <= new_entry;
    end
  end

  assign in_ready    = in_ready_q;
  assign halted      = halted_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized bench for decode_stage with a queue-based
// reference model plus directed scenarios pinned by hand-computed literals.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int DW = 2;
  localparam int IW = 32;
  localparam int CW = 32;

  localparam logic [31:0] ADD1 = 32'h001080B3; // add x1,x1,x1
  localparam logic [31:0] BEQ0 = 32'h00000063; // beq x0,x0,0
  localparam logic [31:0] ADD0 = 32'h00108033; // add x0,x1,x1 (nop)
  localparam logic [31:0] NOPI = 32'h00000013; // addi x0,x0,0 (nop)
  localparam logic [31:0] ADD5 = 32'h001082B3; // add x5,x1,x1
  localparam logic [31:0] ADD6 = 32'h00108333; // add x6,x1,x1
  localparam logic [31:0] ADD7 = 32'h001083B3; // add x7,x1,x1

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic [DW*IW-1:0]    in_instr = '0;
  logic [DW-1:0]       in_lane_mask = '0;
  logic                in_ready, out_valid, halted;
  uop_t [DW-1:0]       out_uop;
  logic [DW-1:0]       out_lane_valid, out_invalid;
  logic [CW-1:0]       instr_count;

  decode_stage #(.INSTR_WIDTH(IW), .DECODE_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_lane_mask(in_lane_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_uop(out_uop), .out_lane_valid(out_lane_valid),
    .out_invalid(out_invalid), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    uop_t [DW-1:0] uop;
    logic [DW-1:0] lv;
    logic [DW-1:0] inv;
  } bund_t;

  bund_t         mq[$];
  bit            m_halted = 1'b0;
  bit            m_ready  = 1'b1;
  logic [CW-1:0] m_cnt    = '0;
  int            total = 0;
  int            bad   = 0;
  bit            chk_en = 1'b0;
  int            exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ISA-level reference decode: what each instruction means as a uop.
  function automatic void ref_dec(input logic [31:0] w, output uop_t u, output bit ill);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [11:0] s12;
    op  = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    s12 = {w[31:25], w[11:7]};
    u = '0;
    u.funct3 = f3;
    u.rd  = w[11:7];
    u.rs1 = w[19:15];
    u.rs2 = w[24:20];
    ill = 1'b0;
    case (op)
      7'h37, 7'h17: begin u.fu = FU_ALU; u.rd_we = 1'b1; u.imm = w & 32'hFFFFF000; end
      7'h6F: begin u.fu = FU_JMP; u.rd_we = 1'b1; u.imm = {{11{j21[20]}}, j21}; end
      7'h67: begin u.fu = FU_JMP; u.rd_we = 1'b1; u.imm = $unsigned($signed(w) >>> 20); ill = (f3 != 0); end
      7'h63: begin u.fu = FU_BR; u.imm = {{19{b13[12]}}, b13}; ill = (f3 == 2) || (f3 == 3); end
      7'h03: begin u.fu = FU_LD; u.rd_we = 1'b1; u.imm = $unsigned($signed(w) >>> 20); ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
      7'h23: begin u.fu = FU_ST; u.imm = {{20{s12[11]}}, s12}; ill = (f3 > 2); end
      7'h13: begin
        u.fu = FU_ALU; u.rd_we = 1'b1; u.imm = $unsigned($signed(w) >>> 20);
        u.alt = (f3 == 5) && w[30];
        ill = ((f3 == 1) && (f7 != 0)) || ((f3 == 5) && !(f7 inside {7'h00, 7'h20}));
      end
      7'h33: begin
        u.fu = FU_ALU; u.rd_we = 1'b1; u.alt = w[30];
        ill = !((f7 == 0) || ((f7 == 7'h20) && (f3 inside {3'd0, 3'd5})));
      end
      7'h0F, 7'h73: u.fu = FU_SYS;
      default: ill = 1'b1;
    endcase
    u.nop = !ill && (u.fu == FU_ALU) && (u.rd == 0);
  endfunction

  // What the stage should enqueue for an accepted fetch bundle.
  function automatic bund_t build(input logic [DW*IW-1:0] ins, input logic [DW-1:0] m, output bit keep);
    bund_t b = '0;
    bit    seen = 1'b0;
    uop_t  u;
    bit    ill;
    for (int i = 0; i < DW; i++) begin
      ref_dec(ins[i*IW +: IW], u, ill);
      b.uop[i] = u;
      if (m[i] && !seen) begin
        b.inv[i] = ill;
`ifdef DECODE_NOP_ELIM_EN
        b.lv[i] = ill || !u.nop;
`else
        b.lv[i] = 1'b1;
`endif
        if (ill) seen = 1'b1;
      end
    end
`ifdef DECODE_NOP_ELIM_EN
    keep = (|b.lv) || (|b.inv);
`else
    keep = 1'b1;
`endif
    return b;
  endfunction

  // Reference model: queue of pending bundles, updated at each clock edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_halted = 1'b0;
        m_ready  = 1'b1;
        m_cnt    = '0;
      end else begin
        bit    inf, outf, kp;
        bund_t nb;
        inf  = in_valid && m_ready;
        outf = (mq.size() > 0) && out_ready;
        if (flush) begin
          mq.delete();
          m_halted = 1'b0;
        end else begin
          if (outf) begin
            m_cnt = m_cnt + CW'($countones(mq[0].lv));
            void'(mq.pop_front());
          end
          if (inf) begin
            nb = build(in_instr, in_lane_mask, kp);
            if (kp) begin
              mq.push_back(nb);
              if (|nb.inv) m_halted = 1'b1;
            end
          end
        end
        m_ready = (mq.size() < 2) && !m_halted;
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        chk("out_valid", out_valid, mq.size() > 0);
        chk("in_ready", in_ready, m_ready);
        chk("halted", halted, m_halted);
        chk("instr_count", instr_count, m_cnt);
        if (mq.size() > 0) begin
          chk("lane_valid", out_lane_valid, mq[0].lv);
          chk("invalid", out_invalid, mq[0].inv);
          for (int i = 0; i < DW; i++) begin
            if (mq[0].lv[i] && !mq[0].inv[i]) chk("uop", out_uop[i], mq[0].uop[i]);
          end
        end
      end
    end
  end

  task automatic put(input bit v, input logic [31:0] i0, input logic [31:0] i1,
                     input logic [1:0] m, input bit ordy, input bit fl);
    in_valid     = v;
    in_instr     = {i1, i0};
    in_lane_mask = m;
    out_ready    = ordy;
    flush        = fl;
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r, w;
    logic [6:0]  op;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
      4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h23;
      7, 8, 9: op = 7'h13;
      10, 11, 12: op = 7'h33;
      13: op = 7'h0F; 14: op = 7'h73;
      default: return r;
    endcase
    w = {r[31:7], op};
    if (((op == 7'h13) || (op == 7'h33)) && ($urandom % 8 != 0))
      w[31:25] = r[5] ? 7'h20 : 7'h00;
    if ($urandom % 4 == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    // Reset values.
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_lane_valid", out_lane_valid, 2'b00);
    chk("rst_invalid", out_invalid, 2'b00);
    chk("rst_uop", out_uop, '0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_count", instr_count, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Two legal lanes straight through.
    put(1, ADD1, BEQ0, 2'b11, 1, 0);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_lane_valid", out_lane_valid, 2'b11);
    chk("t1_invalid", out_invalid, 2'b00);
    chk("t1_rd0", out_uop[0].rd, 5'd1);
    chk("t1_fu1", out_uop[1].fu, FU_BR);
    put(0, 0, 0, 2'b00, 1, 0);
    exp_cnt = 2;
    chk("t1_count", instr_count, exp_cnt);

    // Nop lanes.
    put(1, ADD0, ADD1, 2'b11, 1, 0);
`ifdef DECODE_NOP_ELIM_EN
    chk("t2_lane_valid", out_lane_valid, 2'b10);
    exp_cnt += 1;
`else
    chk("t2_lane_valid", out_lane_valid, 2'b11);
    exp_cnt += 2;
`endif
    put(0, 0, 0, 2'b00, 1, 0);
    chk("t2_count", instr_count, exp_cnt);
    put(1, ADD0, NOPI, 2'b11, 1, 0);
`ifdef DECODE_NOP_ELIM_EN
    chk("t2_allnop_valid", out_valid, 1'b0);
`else
    chk("t2_allnop_valid", out_valid, 1'b1);
    exp_cnt += 2;
`endif
    put(0, 0, 0, 2'b00, 1, 0);
    chk("t2_count2", instr_count, exp_cnt);

    // Illegal lane 0 squashes lane 1 and halts intake.
    put(1, 32'hFFFFFFFF, ADD1, 2'b11, 1, 0);
    chk("t3_lane_valid", out_lane_valid, 2'b01);
    chk("t3_invalid", out_invalid, 2'b01);
    chk("t3_halted", halted, 1'b1);
    chk("t3_in_ready", in_ready, 1'b0);
    repeat (3) put(1, ADD1, ADD1, 2'b11, 1, 0);
    exp_cnt += 1;
    chk("t3_in_ready_held", in_ready, 1'b0);
    chk("t3_drained", out_valid, 1'b0);
    chk("t3_count", instr_count, exp_cnt);
    put(0, 0, 0, 2'b00, 1, 1);
    chk("t3_unhalt", halted, 1'b0);
    chk("t3_ready_back", in_ready, 1'b1);

    // Back-pressure: three bundles offered, two captured, drained in order.
    put(1, ADD5, ADD5, 2'b11, 0, 0);
    chk("t4_ready_one", in_ready, 1'b1);
    put(1, ADD6, ADD6, 2'b11, 0, 0);
    chk("t4_ready_full", in_ready, 1'b0);
    repeat (2) begin
      put(1, ADD7, ADD7, 2'b11, 0, 0);
      chk("t4_stable_valid", out_valid, 1'b1);
      chk("t4_stable_rd", out_uop[0].rd, 5'd5);
    end
    put(0, 0, 0, 2'b00, 1, 0);
    chk("t4_second_rd", out_uop[0].rd, 5'd6);
    put(0, 0, 0, 2'b00, 1, 0);
    exp_cnt += 4;
    chk("t4_empty", out_valid, 1'b0);
    chk("t4_count", instr_count, exp_cnt);

    // Flush while full with both handshakes offered.
    put(1, ADD5, ADD5, 2'b11, 0, 0);
    put(1, ADD6, ADD6, 2'b11, 0, 0);
    put(1, ADD7, ADD7, 2'b11, 1, 1);
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_in_ready", in_ready, 1'b1);
    chk("t5_count", instr_count, exp_cnt);
    put(0, 0, 0, 2'b00, 0, 0);

    // Asynchronous reset between edges while full.
    put(1, ADD5, ADD5, 2'b11, 0, 0);
    put(1, ADD6, ADD6, 2'b11, 0, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_lane_valid", out_lane_valid, 2'b00);
    chk("t6_uop", out_uop, '0);
    chk("t6_halted", halted, 1'b0);
    chk("t6_count", instr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      in_valid     = ($urandom % 4) != 0;
      in_instr     = {gen_instr(), gen_instr()};
      in_lane_mask = DW'($urandom);
      out_ready    = (n < 1500) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
      flush        = halted ? (($urandom % 3) == 0) : (($urandom % 50) == 0);
      @(negedge clk);
    end

    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
